// File: rtl/cpu_pkg.sv
// Shared CPU types: condition codes, branch kinds and the NZCV flag struct.
// Used by decode, the ID/EX stage and the EX/MEM stage.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_UNCOND = 2'd1,
    BR_CBZ    = 2'd2,
    BR_BCOND  = 2'd3
  } br_kind_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: decides whether a B.cond is taken from NZCV.
// Purely combinational; shared by the EX/MEM stage.
module cond_eval
  import cpu_pkg::*;
(
  input  cond_e cond,
  input  nzcv_t nzcv,
  output logic  taken
);

  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = nzcv.z;
      COND_NE: taken = !nzcv.z;
      COND_HS: taken = nzcv.c;
      COND_LO: taken = !nzcv.c;
      COND_MI: taken = nzcv.n;
      COND_PL: taken = !nzcv.n;
      COND_VS: taken = nzcv.v;
      COND_VC: taken = !nzcv.v;
      COND_HI: taken = nzcv.c && !nzcv.z;
      COND_LS: taken = !nzcv.c || nzcv.z;
      COND_GE: taken = (nzcv.n == nzcv.v);
      COND_LT: taken = (nzcv.n != nzcv.v);
      COND_GT: taken = !nzcv.z && (nzcv.n == nzcv.v);
      COND_LE: taken = nzcv.z || (nzcv.n != nzcv.v);
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: carries the ALU result and memory controls into MEM,
// owns the architectural NZCV flags and registers the branch decision.
module ex_mem_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [63:0] alu_result,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry_out,
  input  logic        set_flags,
  input  logic [1:0]  br_kind,
  input  logic [3:0]  cond,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] store_data,
  output logic        out_valid,
  output logic [63:0] result_q,
  output logic [4:0]  rd_q,
  output logic        reg_write_q,
  output logic        mem_read_q,
  output logic        mem_write_q,
  output logic [63:0] store_data_q,
  output logic [3:0]  flags_q,
  output logic        branch_taken_q
);

  logic        r_valid;
  logic [63:0] r_result;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [63:0] r_store_data;
  nzcv_t       r_flags;
  logic        r_branch_taken;

  logic        w_cond_taken;
  logic        w_branch_decision;
  logic        w_advance;
  logic        w_load;
  br_kind_e    w_br_kind;

  assign w_br_kind = br_kind_e'(br_kind);

  // Flush wins over stall; anything that advances without a live instruction is a bubble.
  assign w_advance = !stall || flush;
  assign w_load    = w_advance && !flush && in_valid;

  // Evaluated against the flags held before this edge, so an instruction never sees its own flag write.
  cond_eval u_cond_eval (
    .cond  (cond_e'(cond)),
    .nzcv  (r_flags),
    .taken (w_cond_taken)
  );

  always_comb begin
    w_branch_decision = 1'b0;
    case (w_br_kind)
      BR_NONE:   w_branch_decision = 1'b0;
      BR_UNCOND: w_branch_decision = 1'b1;
      BR_CBZ:    w_branch_decision = alu_zero;
      BR_BCOND:  w_branch_decision = w_cond_taken;
      default:   w_branch_decision = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_result       <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_store_data   <= '0;
      r_flags        <= '0;
      r_branch_taken <= 1'b0;
    end else if (w_load) begin
      r_valid        <= 1'b1;
      r_result       <= alu_result;
      r_rd           <= rd;
      r_reg_write    <= reg_write;
      r_mem_read     <= mem_read;
      r_mem_write    <= mem_write;
      r_store_data   <= store_data;
      r_branch_taken <= w_branch_decision;
      if (set_flags) begin
        r_flags <= '{n: alu_negative, z: alu_zero, c: alu_carry_out, v: alu_overflow};
      end
    end else if (w_advance) begin
      // Bubble: data fields keep their stale contents, only the side-effecting controls drop.
      r_valid        <= 1'b0;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_branch_taken <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign result_q       = r_result;
  assign rd_q           = r_rd;
  assign reg_write_q    = r_reg_write;
  assign mem_read_q     = r_mem_read;
  assign mem_write_q    = r_mem_write;
  assign store_data_q   = r_store_data;
  assign flags_q        = r_flags;
  assign branch_taken_q = r_branch_taken;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a behavioural model predicts every cycle's
// outputs, a monitor pops and compares them; directed scenarios add fixed-value checks.
module tb_ex_mem_stage;

  typedef struct {
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [63:0] result;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
    logic        set_flags;
    logic [1:0]  br_kind;
    logic [3:0]  cond;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] store_data;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [63:0] result;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] store_data;
    logic [3:0]  flags;
    logic        taken;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [63:0] alu_result;
  logic        alu_negative;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_carry_out;
  logic        set_flags;
  logic [1:0]  br_kind;
  logic [3:0]  cond;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] store_data;
  logic        out_valid;
  logic [63:0] result_q;
  logic [4:0]  rd_q;
  logic        reg_write_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [63:0] store_data_q;
  logic [3:0]  flags_q;
  logic        branch_taken_q;

  int   vectors;
  int   miscompares;
  exp_t model;
  exp_t expQ[$];
  exp_t monExp;

  ex_mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .in_valid       (in_valid),
    .alu_result     (alu_result),
    .alu_negative   (alu_negative),
    .alu_zero       (alu_zero),
    .alu_overflow   (alu_overflow),
    .alu_carry_out  (alu_carry_out),
    .set_flags      (set_flags),
    .br_kind        (br_kind),
    .cond           (cond),
    .rd             (rd),
    .reg_write      (reg_write),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .store_data     (store_data),
    .out_valid      (out_valid),
    .result_q       (result_q),
    .rd_q           (rd_q),
    .reg_write_q    (reg_write_q),
    .mem_read_q     (mem_read_q),
    .mem_write_q    (mem_write_q),
    .store_data_q   (store_data_q),
    .flags_q        (flags_q),
    .branch_taken_q (branch_taken_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ARM-style evaluation: pick a base test from cond[3:1], invert on cond[0] (except the always pair).
  function automatic logic condHolds(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = (n == v) & ~z;
      default: base = 1'b1;
    endcase
    if (cc[0] && cc[3:1] != 3'd7) base = ~base;
    return base;
  endfunction

  function automatic exp_t stepModel(input exp_t cur, input stim_t s);
    exp_t nx;
    nx = cur;
    if (s.reset) begin
      nx = '{valid: 0, result: 0, rd: 0, reg_write: 0, mem_read: 0, mem_write: 0,
             store_data: 0, flags: 0, taken: 0};
    end else if (s.stall && !s.flush) begin
      nx = cur;
    end else if (s.flush || !s.in_valid) begin
      nx.valid = 0; nx.reg_write = 0; nx.mem_read = 0; nx.mem_write = 0; nx.taken = 0;
    end else begin
      nx.valid      = 1;
      nx.result     = s.result;
      nx.rd         = s.rd;
      nx.reg_write  = s.reg_write;
      nx.mem_read   = s.mem_read;
      nx.mem_write  = s.mem_write;
      nx.store_data = s.store_data;
      case (s.br_kind)
        2'd0:    nx.taken = 0;
        2'd1:    nx.taken = 1;
        2'd2:    nx.taken = s.z;
        default: nx.taken = condHolds(s.cond, cur.flags);
      endcase
      if (s.set_flags) nx.flags = {s.n, s.z, s.c, s.v};
    end
    return nx;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s = '{reset: 0, stall: 0, flush: 0, in_valid: 0, result: 0, n: 0, z: 0, c: 0, v: 0,
          set_flags: 0, br_kind: 0, cond: 0, rd: 0, reg_write: 0, mem_read: 0,
          mem_write: 0, store_data: 0};
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.reset      = ($urandom_range(0, 39) == 0);
    s.stall      = ($urandom_range(0, 3) == 0);
    s.flush      = ($urandom_range(0, 7) == 0);
    s.in_valid   = ($urandom_range(0, 4) != 0);
    s.result     = {$urandom, $urandom};
    s.n          = 1'($urandom);
    s.z          = 1'($urandom);
    s.c          = 1'($urandom);
    s.v          = 1'($urandom);
    s.set_flags  = 1'($urandom);
    s.br_kind    = 2'($urandom);
    s.cond       = 4'($urandom);
    s.rd         = 5'($urandom);
    s.reg_write  = 1'($urandom);
    s.mem_read   = 1'($urandom);
    s.mem_write  = 1'($urandom);
    s.store_data = {$urandom, $urandom};
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    reset         = s.reset;
    stall         = s.stall;
    flush         = s.flush;
    in_valid      = s.in_valid;
    alu_result    = s.result;
    alu_negative  = s.n;
    alu_zero      = s.z;
    alu_carry_out = s.c;
    alu_overflow  = s.v;
    set_flags     = s.set_flags;
    br_kind       = s.br_kind;
    cond          = s.cond;
    rd            = s.rd;
    reg_write     = s.reg_write;
    mem_read      = s.mem_read;
    mem_write     = s.mem_write;
    store_data    = s.store_data;
    model = stepModel(model, s);
    expQ.push_back(model);
    @(posedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle after an edge the DUT presents the next predicted bundle.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput("sb_out_valid", 64'(out_valid), 64'(monExp.valid));
      checkOutput("sb_result_q", result_q, monExp.result);
      checkOutput("sb_rd_q", 64'(rd_q), 64'(monExp.rd));
      checkOutput("sb_reg_write_q", 64'(reg_write_q), 64'(monExp.reg_write));
      checkOutput("sb_mem_read_q", 64'(mem_read_q), 64'(monExp.mem_read));
      checkOutput("sb_mem_write_q", 64'(mem_write_q), 64'(monExp.mem_write));
      checkOutput("sb_store_data_q", store_data_q, monExp.store_data);
      checkOutput("sb_flags_q", 64'(flags_q), 64'(monExp.flags));
      checkOutput("sb_branch_taken_q", 64'(branch_taken_q), 64'(monExp.taken));
    end
  end

  initial begin
    stim_t s;
    vectors     = 0;
    miscompares = 0;
    model = '{valid: 0, result: 0, rd: 0, reg_write: 0, mem_read: 0, mem_write: 0,
              store_data: 0, flags: 0, taken: 0};
    {reset, stall, flush, in_valid, alu_negative, alu_zero, alu_overflow, alu_carry_out} = '0;
    {set_flags, br_kind, cond, rd, reg_write, mem_read, mem_write} = '0;
    alu_result = '0;
    store_data = '0;

    s = idleStim(); s.reset = 1;
    applyStimulus(s);
    #2;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_flags", 64'(flags_q), 64'd0);

    // SUBS setting Z and C, then B.EQ consumes them
    s = idleStim(); s.in_valid = 1; s.z = 1; s.c = 1; s.set_flags = 1; s.rd = 5'd3; s.reg_write = 1;
    applyStimulus(s);
    #2 checkOutput("subs_flags", 64'(flags_q), 64'h6);
    s = idleStim(); s.in_valid = 1; s.br_kind = 2'd3; s.cond = 4'h0;
    applyStimulus(s);
    #2 checkOutput("beq_taken", 64'(branch_taken_q), 64'd1);

    // flag write must not influence the same instruction's decision
    s = idleStim(); s.reset = 1;
    applyStimulus(s);
    s = idleStim(); s.in_valid = 1; s.set_flags = 1; s.n = 1; s.br_kind = 2'd3; s.cond = 4'h4;
    applyStimulus(s);
    #2;
    checkOutput("iso_taken", 64'(branch_taken_q), 64'd0);
    checkOutput("iso_flags", 64'(flags_q), 64'h8);

    // stall hold for three cycles with changing inputs
    s = idleStim(); s.reset = 1;
    applyStimulus(s);
    s = idleStim(); s.in_valid = 1; s.result = 64'h7FFFFFFFFFFFFFFF; s.rd = 5'd5; s.reg_write = 1;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = randStim(); s.reset = 0; s.flush = 0; s.stall = 1; s.in_valid = 1; s.set_flags = 1;
      applyStimulus(s);
      #2;
      checkOutput("stall_result", result_q, 64'h7FFFFFFFFFFFFFFF);
      checkOutput("stall_rd", 64'(rd_q), 64'd5);
      checkOutput("stall_flags", 64'(flags_q), 64'd0);
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
    end

    // flush beats stall
    s = idleStim(); s.in_valid = 1; s.set_flags = 1; s.n = 1; s.c = 1; s.reg_write = 1;
    applyStimulus(s);
    s = idleStim(); s.stall = 1; s.flush = 1; s.in_valid = 1; s.reg_write = 1; s.set_flags = 1; s.z = 1;
    applyStimulus(s);
    #2;
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_reg_write", 64'(reg_write_q), 64'd0);
    checkOutput("flush_flags", 64'(flags_q), 64'hA);

    // signed conditions against N=1, V=1
    s = idleStim(); s.in_valid = 1; s.set_flags = 1; s.n = 1; s.v = 1;
    applyStimulus(s);
    #2 checkOutput("nv_flags", 64'(flags_q), 64'h9);
    s = idleStim(); s.in_valid = 1; s.br_kind = 2'd3; s.cond = 4'hA;
    applyStimulus(s);
    #2 checkOutput("bge_taken", 64'(branch_taken_q), 64'd1);
    s.cond = 4'hB;
    applyStimulus(s);
    #2 checkOutput("blt_taken", 64'(branch_taken_q), 64'd0);
    s.cond = 4'hC;
    applyStimulus(s);
    #2 checkOutput("bgt_taken", 64'(branch_taken_q), 64'd1);

    // reset while a store is in flight, with stall also high
    s = idleStim(); s.in_valid = 1; s.mem_write = 1; s.reg_write = 1; s.result = 64'hDEAD_BEEF_0000_1234;
    s.store_data = 64'h1111_2222_3333_4444; s.rd = 5'd9;
    applyStimulus(s);
    s = idleStim(); s.reset = 1; s.stall = 1; s.in_valid = 1;
    applyStimulus(s);
    #2;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mem_write", 64'(mem_write_q), 64'd0);
    checkOutput("rst_result", result_q, 64'd0);
    checkOutput("rst_store_data", store_data_q, 64'd0);
    checkOutput("rst_rd", 64'(rd_q), 64'd0);
    checkOutput("rst_flags", 64'(flags_q), 64'd0);

    for (int i = 0; i < 400; i++) begin
      s = randStim();
      applyStimulus(s);
    end

    repeat (3) @(posedge clk);
    #2;
    checkOutput("sb_drained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
